bus_read_tracker: RTL
=====================

# bus_read_tracker

Synthesizable companion to the CPU bus monitor. Passively snoops one CPU read channel (instruction or data read: address handshake, then data handshake) and pairs each data beat with its oldest outstanding address in order. Emits one registered trace record per completed read, with access latency. Flags protocol violations with sticky error bits. Sits beside the core on the bus wires, feeding trace/debug logic; it never drives the bus.

## Interface
- ADDR_WIDTH, 32, width of snooped address
- DATA_WIDTH, 32, width of snooped read data
- DEPTH, 4, max outstanding reads tracked; power of 2, ≥2
- LAT_WIDTH, 16, width of cycle stamp and latency

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- addr_valid  in  1  snooped read-address valid
- addr_ready  in  1  snooped read-address ready
- addr  in  ADDR_WIDTH  snooped read address
- data_valid  in  1  snooped read-data valid
- data_ready  in  1  snooped read-data ready
- data  in  DATA_WIDTH  snooped read data
- trace_valid  out  1  one-cycle pulse: trace record valid
- trace_addr  out  ADDR_WIDTH  address of completed read
- trace_data  out  DATA_WIDTH  data of completed read
- trace_latency  out  LAT_WIDTH  cycles from address handshake to data handshake
- outstanding  out  $clog2(DEPTH+1)  reads accepted but not yet completed
- err_overflow  out  1  sticky: address accepted while DEPTH already outstanding
- err_underflow  out  1  sticky: data accepted with nothing outstanding

## Operation
- Address handshake (A): addr_valid && addr_ready. Data handshake (D): data_valid && data_ready. Any other combination is ignored.
- Free-running counter `now`, LAT_WIDTH bits, +1 every cycle, wraps modulo 2^LAT_WIDTH.
- On A: push {addr, now} into a DEPTH-entry circular FIFO (write pointer wraps at DEPTH).
- On D with outstanding>0: pop head; next cycle trace_valid=1, trace_addr=head addr, trace_data=data, trace_latency=(now − head stamp) mod 2^LAT_WIDTH.
- D with outstanding==0: set err_underflow; no trace; no pop.
- A with outstanding==DEPTH and no same-cycle pop: set err_overflow; address dropped; count unchanged.
- Same-cycle A and D: pop evaluated against pre-cycle state, then push. With outstanding==0, the D is underflow and the A is pushed (count→1). A same-cycle address never pairs with that cycle's data. With outstanding==DEPTH, pop and push both succeed; count stays DEPTH; no overflow.
- outstanding: +1 on push, −1 on pop, unchanged on both or neither; range 0..DEPTH.
- Error bits are sticky until rst; operation continues after errors.

## Timing
- Reset values: trace_valid=0, trace_addr=0, trace_data=0, trace_latency=0, outstanding=0, err_overflow=0, err_underflow=0, now=0, both FIFO pointers=0.
- rst mid-operation discards all outstanding entries; the first cycle after rst deasserts behaves as empty.
- Handshakes seen while rst=1 are ignored.
- Trace latency: record appears exactly 1 cycle after the D edge. trace_valid is high for exactly 1 cycle per D; back-to-back D cycles give back-to-back pulses.
- Minimum reported latency is 1 (A and D cannot pair in one cycle).
- trace_addr/data/latency hold their last values when trace_valid=0.
- outstanding and error bits update on the handshake edge; they are visible the next cycle.
- Latencies ≥ 2^LAT_WIDTH alias modulo 2^LAT_WIDTH; this is a documented limitation, not an error.

## Test plan
- Single read: A addr=0x00000010 at cycle 5, D data=0xDEADBEEF at cycle 8 -> trace_valid at cycle 9, addr 0x10, data 0xDEADBEEF, latency 3; outstanding 1 then 0.
- Pipelined: A 0x0,0x4,0x8 on cycles 1–3, D 0xA,0xB,0xC on cycles 4–6 -> three consecutive pulses pairing 0x0/0xA, 0x4/0xB, 0x8/0xC, each latency 3; peak outstanding 3.
- Full plus simultaneous: fill DEPTH=4, then A and D in the same cycle -> oldest pops, new address pushed, outstanding stays 4, err_overflow=0. A fifth A with no D -> err_overflow=1, that address never traced.
- Underflow: D with outstanding=0 and same-cycle A 0x20 -> err_underflow=1, no trace, outstanding=1. A later D pairs with 0x20.
- Wrap: 10 sequential single reads with DEPTH=4 -> all 10 traced in order with correct data (pointer wrap). Stamp taken at now=0xFFFE with D at now=0x0001 -> latency 3.
- Reset mid-flight: 2 outstanding, pulse rst 1 cycle -> outstanding=0, errors cleared. A subsequent D -> err_underflow=1.

Source files
------------

// File: rtl/bus_read_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bus_read_tracker
// Description : Passive snooper for one CPU read channel. Pairs each data
//               handshake with the oldest outstanding address handshake
//               (in order), emits a registered one-cycle trace record with
//               access latency, and flags protocol violations with sticky
//               overflow/underflow bits. Never drives the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_read_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int LAT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         addr_valid,
    input  logic                         addr_ready,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic                         data_valid,
    input  logic                         data_ready,
    input  logic [DATA_WIDTH-1:0]        data,
    output logic                         trace_valid,
    output logic [ADDR_WIDTH-1:0]        trace_addr,
    output logic [DATA_WIDTH-1:0]        trace_data,
    output logic [LAT_WIDTH-1:0]         trace_latency,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    // Pointer width relies on DEPTH being a power of two so that the
    // pointers wrap naturally at DEPTH.
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_FULL_COUNT = C_CNT_W'(DEPTH);
    localparam logic [C_CNT_W-1:0] C_EMPTY_COUNT = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LAT_WIDTH-1:0]  r_now;
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;
    logic [ADDR_WIDTH-1:0] r_addr_mem  [DEPTH];
    logic [LAT_WIDTH-1:0]  r_stamp_mem [DEPTH];

    logic                  r_trace_valid;
    logic [ADDR_WIDTH-1:0] r_trace_addr;
    logic [DATA_WIDTH-1:0] r_trace_data;
    logic [LAT_WIDTH-1:0]  r_trace_latency;
    logic                  r_err_overflow;
    logic                  r_err_underflow;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_addr_hs;
    logic w_data_hs;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_underflow;
    logic w_overflow;

    // Pop is judged against the pre-cycle occupancy, so a same-cycle
    // address can never satisfy the data beat of that cycle; a push into a
    // full FIFO is legal only when the head is leaving in the same cycle.
    always_comb begin
        w_addr_hs   = addr_valid && addr_ready;
        w_data_hs   = data_valid && data_ready;
        w_empty     = (r_count == C_EMPTY_COUNT);
        w_full      = (r_count == C_FULL_COUNT);
        w_pop       = w_data_hs && !w_empty;
        w_push      = w_addr_hs && (!w_full || w_pop);
        w_underflow = w_data_hs && w_empty;
        w_overflow  = w_addr_hs && w_full && !w_pop;
    end

    // Free-running cycle stamp; wraps modulo 2^LAT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_now <= '0;
        end else begin
            r_now <= r_now + 1'b1;
        end
    end

    // FIFO storage: address and arrival stamp of each accepted read.
    // Contents need no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_addr_mem[r_wr_ptr]  <= addr;
            r_stamp_mem[r_wr_ptr] <= r_now;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Trace record: registered one cycle after the data handshake; fields
    // hold their last value while no record is being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trace_valid   <= 1'b0;
            r_trace_addr    <= '0;
            r_trace_data    <= '0;
            r_trace_latency <= '0;
        end else begin
            r_trace_valid <= w_pop;
            if (w_pop) begin
                r_trace_addr    <= r_addr_mem[r_rd_ptr];
                r_trace_data    <= data;
                r_trace_latency <= r_now - r_stamp_mem[r_rd_ptr];
            end
        end
    end

    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign trace_valid   = r_trace_valid;
    assign trace_addr    = r_trace_addr;
    assign trace_data    = r_trace_data;
    assign trace_latency = r_trace_latency;
    assign outstanding   = r_count;
    assign err_overflow  = r_err_overflow;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire
